// File: rtl/midi_pkg.sv
// Shared MIDI parser types and status-byte constants.
package midi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NOTE_D1,
    NOTE_D2,
    SKIP1,
    SKIP2,
    SYSEX
  } state_t;

  localparam logic [3:0] NOTE_OFF     = 4'h8;
  localparam logic [3:0] NOTE_ON      = 4'h9;
  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] SYSEX_END    = 8'hF7;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  localparam logic [4:0] COUNT_MAX = 5'd31;

  // State that expects the first data byte of a message with this status nibble.
  function automatic state_t status_state(input logic [3:0] hi);
    state_t s;
    case (hi)
      NOTE_OFF, NOTE_ON:  s = NOTE_D1;
      4'hC, 4'hD:         s = SKIP1;
      4'hA, 4'hB, 4'hE:   s = SKIP2;
      default:            s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/midi_parser.sv
// MIDI byte-stream parser: decodes note-on/off events with running status,
// skips other channel messages and SysEx, ignores realtime bytes, and tracks
// the number of outstanding notes.
module midi_parser
  import midi_pkg::*;
#(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       note_valid,
  output logic       note_on,
  output logic [3:0] channel,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       active
);

  state_t     state, state_next;
  logic [7:0] run_status, run_status_next;
  logic [6:0] key, key_next;
  logic [4:0] count, count_next;
  logic       emit;
  logic       emit_on;

  // Next-state, running status, event decode and held-note count update.
  always_comb begin
    state_next      = state;
    run_status_next = run_status;
    key_next        = key;
    emit            = 1'b0;
    emit_on         = 1'b0;
    count_next      = count;

    if (data_valid) begin
      if (!data[7]) begin
        case (state)
          NOTE_D1: begin
            key_next   = data[6:0];
            state_next = NOTE_D2;
          end
          NOTE_D2: begin
            state_next = status_state(run_status[7:4]);
            emit       = OMNI || (run_status[3:0] == CHANNEL);
            emit_on    = (run_status[7:4] == NOTE_ON) && (data[6:0] != '0);
          end
          SKIP2:   state_next = SKIP1;
          SKIP1:   state_next = status_state(run_status[7:4]);
          default: state_next = state;
        endcase
      end else if (data < REALTIME_MIN) begin
        if (data[7:4] != 4'hF) begin
          run_status_next = data;
          state_next      = status_state(data[7:4]);
        end else begin
          run_status_next = '0;
          state_next      = (data == SYSEX_START) ? SYSEX : IDLE;
        end
      end
    end

    if (emit) begin
      if (emit_on && (count != COUNT_MAX))
        count_next = count + 5'd1;
      else if (!emit_on && (count != '0))
        count_next = count - 5'd1;
    end
  end

  // Parser state, running status and latched key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      run_status <= '0;
      key        <= '0;
    end else begin
      state      <= state_next;
      run_status <= run_status_next;
      key        <= key_next;
    end
  end

  // Event outputs, held until the next emitted event, plus count/active.
  always_ff @(posedge clk) begin
    if (rst) begin
      note_valid <= 1'b0;
      note_on    <= 1'b0;
      channel    <= '0;
      note       <= '0;
      velocity   <= '0;
      count      <= '0;
      active     <= 1'b0;
    end else begin
      note_valid <= emit;
      if (emit) begin
        note_on  <= emit_on;
        channel  <= run_status[3:0];
        note     <= key;
        velocity <= data[6:0];
      end
      count  <= count_next;
      active <= (count_next != '0);
    end
  end

endmodule

// File: tb/tb_midi_parser.sv
// Self-checking bench for midi_parser: directed vector table, hand-written
// corner sequences, and a random byte stream against a message-level model.
module tb_midi_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       data_valid;

  logic       a_note_valid, a_note_on, a_active;
  logic [3:0] a_channel;
  logic [6:0] a_note, a_velocity;
  logic       b_note_valid, b_note_on, b_active;
  logic [3:0] b_channel;
  logic [6:0] b_note, b_velocity;

  always #5 clk = ~clk;

  midi_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) dut_a (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .note_valid(a_note_valid), .note_on(a_note_on), .channel(a_channel),
    .note(a_note), .velocity(a_velocity), .active(a_active)
  );

  midi_parser #(.OMNI(1'b0), .CHANNEL(4'd2)) dut_b (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .note_valid(b_note_valid), .note_on(b_note_on), .channel(b_channel),
    .note(b_note), .velocity(b_velocity), .active(b_active)
  );

  // Message-level model: a status byte, how many data bytes it has collected,
  // and the last emitted event plus outstanding-note count.
  typedef struct {
    int status;
    int got;
    int d0;
    bit v;
    bit on;
    int ch;
    int note;
    int vel;
    int cnt;
  } mdl_t;

  typedef struct {
    logic [7:0] b;
    bit         v;
    bit         on;
    logic [3:0] ch;
    logic [6:0] note;
    logic [6:0] vel;
    bit         act;
  } vec_t;

  mdl_t ma, mb;
  vec_t tbl[24];
  int   checks = 0;
  int   errors = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.status = -1; m.got = 0; m.d0 = 0; m.v = 0; m.on = 0;
    m.ch = 0; m.note = 0; m.vel = 0; m.cnt = 0;
    return m;
  endfunction

  function automatic int need_of(int st);
    int hi;
    hi = st >> 4;
    if (hi == 8 || hi == 9 || hi == 10 || hi == 11 || hi == 14) return 2;
    if (hi == 12 || hi == 13) return 1;
    return 0;
  endfunction

  function automatic mdl_t mdl_byte(mdl_t m_in, int b, bit omni, int chf);
    mdl_t m;
    int   c;
    m = m_in;
    m.v = 0;
    if (b < 128) begin
      if (m.status >= 0) begin
        if (m.got == 0) m.d0 = b;
        m.got++;
        if (m.got == need_of(m.status)) begin
          m.got = 0;
          if ((m.status >> 4) == 8 || (m.status >> 4) == 9) begin
            c = m.status & 15;
            if (omni || c == chf) begin
              m.v    = 1;
              m.on   = ((m.status >> 4) == 9) && (b != 0);
              m.ch   = c;
              m.note = m.d0;
              m.vel  = b;
              if (m.on) m.cnt = (m.cnt < 31) ? m.cnt + 1 : 31;
              else      m.cnt = (m.cnt > 0) ? m.cnt - 1 : 0;
            end
          end
        end
      end
    end else if (b < 'hF0) begin
      m.status = b;
      m.got    = 0;
    end else if (b < 'hF8) begin
      m.status = -1;
      m.got    = 0;
    end
    return m;
  endfunction

  function automatic vec_t mk(logic [7:0] b, bit v, bit on, logic [3:0] ch,
                              logic [6:0] n, logic [6:0] vel, bit act);
    vec_t r;
    r.b = b; r.v = v; r.on = on; r.ch = ch; r.note = n; r.vel = vel; r.act = act;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_a(string tag, bit v, bit on, int ch, int n, int vel, bit act);
    chk({tag, ".a_valid"},  32'(a_note_valid), 32'(v));
    chk({tag, ".a_on"},     32'(a_note_on),    32'(on));
    chk({tag, ".a_ch"},     32'(a_channel),    32'(ch));
    chk({tag, ".a_note"},   32'(a_note),       32'(n));
    chk({tag, ".a_vel"},    32'(a_velocity),   32'(vel));
    chk({tag, ".a_active"}, 32'(a_active),     32'(act));
  endtask

  task automatic check_b(string tag, bit v, bit on, int ch, int n, int vel, bit act);
    chk({tag, ".b_valid"},  32'(b_note_valid), 32'(v));
    chk({tag, ".b_on"},     32'(b_note_on),    32'(on));
    chk({tag, ".b_ch"},     32'(b_channel),    32'(ch));
    chk({tag, ".b_note"},   32'(b_note),       32'(n));
    chk({tag, ".b_vel"},    32'(b_velocity),   32'(vel));
    chk({tag, ".b_active"}, 32'(b_active),     32'(act));
  endtask

  task automatic check_models(string tag);
    check_a(tag, ma.v, ma.on, ma.ch, ma.note, ma.vel, ma.cnt != 0);
    check_b(tag, mb.v, mb.on, mb.ch, mb.note, mb.vel, mb.cnt != 0);
  endtask

  task automatic step(bit dv, logic [7:0] b);
    data       = b;
    data_valid = dv;
    @(posedge clk);
    #1;
    if (dv) begin
      ma = mdl_byte(ma, int'(b), 1'b1, 0);
      mb = mdl_byte(mb, int'(b), 1'b0, 2);
    end else begin
      ma.v = 0;
      mb.v = 0;
    end
    data_valid = 1'b0;
  endtask

  task automatic do_reset(string tag);
    rst        = 1'b1;
    data_valid = 1'b0;
    @(posedge clk);
    #1;
    ma = mdl_reset();
    mb = mdl_reset();
    check_a(tag, 0, 0, 0, 0, 0, 0);
    check_b(tag, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int         r;

    rst = 1'b1; data = '0; data_valid = 1'b0;
    ma = mdl_reset(); mb = mdl_reset();

    // Single note-on, note-off, running status, realtime interleave, skip+SysEx.
    tbl[0]  = mk(8'h90, 0, 0, 0, 7'h00, 7'h00, 0);
    tbl[1]  = mk(8'h3C, 0, 0, 0, 7'h00, 7'h00, 0);
    tbl[2]  = mk(8'h64, 1, 1, 0, 7'h3C, 7'h64, 1);
    tbl[3]  = mk(8'h80, 0, 1, 0, 7'h3C, 7'h64, 1);
    tbl[4]  = mk(8'h3C, 0, 1, 0, 7'h3C, 7'h64, 1);
    tbl[5]  = mk(8'h40, 1, 0, 0, 7'h3C, 7'h40, 0);
    tbl[6]  = mk(8'h91, 0, 0, 0, 7'h3C, 7'h40, 0);
    tbl[7]  = mk(8'h40, 0, 0, 0, 7'h3C, 7'h40, 0);
    tbl[8]  = mk(8'h50, 1, 1, 1, 7'h40, 7'h50, 1);
    tbl[9]  = mk(8'h40, 0, 1, 1, 7'h40, 7'h50, 1);
    tbl[10] = mk(8'h00, 1, 0, 1, 7'h40, 7'h00, 0);
    tbl[11] = mk(8'h90, 0, 0, 1, 7'h40, 7'h00, 0);
    tbl[12] = mk(8'hF8, 0, 0, 1, 7'h40, 7'h00, 0);
    tbl[13] = mk(8'h3C, 0, 0, 1, 7'h40, 7'h00, 0);
    tbl[14] = mk(8'hFE, 0, 0, 1, 7'h40, 7'h00, 0);
    tbl[15] = mk(8'h64, 1, 1, 0, 7'h3C, 7'h64, 1);
    tbl[16] = mk(8'hB0, 0, 1, 0, 7'h3C, 7'h64, 1);
    tbl[17] = mk(8'h07, 0, 1, 0, 7'h3C, 7'h64, 1);
    tbl[18] = mk(8'h7F, 0, 1, 0, 7'h3C, 7'h64, 1);
    tbl[19] = mk(8'hF0, 0, 1, 0, 7'h3C, 7'h64, 1);
    tbl[20] = mk(8'h12, 0, 1, 0, 7'h3C, 7'h64, 1);
    tbl[21] = mk(8'h34, 0, 1, 0, 7'h3C, 7'h64, 1);
    tbl[22] = mk(8'hF7, 0, 1, 0, 7'h3C, 7'h64, 1);
    tbl[23] = mk(8'h3C, 0, 1, 0, 7'h3C, 7'h64, 1);

    do_reset("reset0");
    for (int i = 0; i < 24; i++) begin
      step(1'b1, tbl[i].b);
      check_a($sformatf("vec%0d", i), tbl[i].v, tbl[i].on, tbl[i].ch,
              tbl[i].note, tbl[i].vel, tbl[i].act);
      check_b($sformatf("vec%0d", i), mb.v, mb.on, mb.ch, mb.note, mb.vel, mb.cnt != 0);
    end

    // Channel filter: channel 3 rejected by the filtered instance, channel 2 accepted.
    do_reset("reset_filt");
    step(1'b1, 8'h93); check_models("filt0");
    step(1'b1, 8'h3C); check_models("filt1");
    step(1'b1, 8'h64); check_models("filt2");
    chk("filt_rej_valid", 32'(b_note_valid), 32'd0);
    chk("filt_rej_active", 32'(b_active), 32'd0);
    step(1'b1, 8'h92); check_models("filt3");
    step(1'b1, 8'h3C); check_models("filt4");
    step(1'b1, 8'h64); check_models("filt5");
    chk("filt_acc_valid", 32'(b_note_valid), 32'd1);
    chk("filt_acc_ch", 32'(b_channel), 32'd2);

    // Reset in the middle of a note message; the next data byte lands in IDLE.
    do_reset("reset_mid0");
    step(1'b1, 8'h90); check_models("mid0");
    step(1'b1, 8'h3C); check_models("mid1");
    do_reset("reset_mid1");
    step(1'b1, 8'h64); check_models("mid2");
    chk("mid_no_event", 32'(a_note_valid), 32'd0);

    // Held-note counter saturation at 31 and floor at 0.
    do_reset("reset_sat");
    step(1'b1, 8'h90);
    for (int i = 0; i < 33; i++) begin
      step(1'b1, 8'(i + 16)); check_models("sat_on_k");
      step(1'b1, 8'h40);      check_models("sat_on_v");
    end
    chk("sat_active_on", 32'(a_active), 32'd1);
    step(1'b1, 8'h80);
    for (int i = 0; i < 33; i++) begin
      step(1'b1, 8'(i + 16)); check_models("sat_off_k");
      step(1'b1, 8'h40);      check_models("sat_off_v");
      if (i == 29) chk("sat_active_30off", 32'(a_active), 32'd1);
      if (i == 30) chk("sat_active_31off", 32'(a_active), 32'd0);
    end
    chk("sat_active_end", 32'(a_active), 32'd0);

    // Random byte stream against the model.
    do_reset("reset_rand");
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 5) begin
        do_reset("rand_rst");
      end else if (r < 100) begin
        step(1'b0, 8'($urandom_range(0, 255)));
        check_models("rand_gap");
      end else begin
        if (r < 520) begin
          b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
        end else if (r < 800) begin
          b = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 3))};
        end else if (r < 880) begin
          b = 8'($urandom_range(8'hF0, 8'hF7));
        end else begin
          b = 8'($urandom_range(8'hF8, 8'hFF));
        end
        step(1'b1, b);
        check_models("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
